// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and lane extend/merge helpers for the data-memory controller
package dm_pkg;

  // Access size/sign codes, identical to the load/store funct3 field
  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dmctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RMW  = 2'd2,
    RESP = 2'd3
  } dm_state_e;

  function automatic logic is_byte(input dmctrl_e ctrl);
    return (ctrl == DM_B) || (ctrl == DM_BU);
  endfunction

  function automatic logic is_half(input dmctrl_e ctrl);
    return (ctrl == DM_H) || (ctrl == DM_HU);
  endfunction

  // Sub-word accesses need a read-modify-write; everything else (incl. undefined codes) is a word
  function automatic logic is_subword(input dmctrl_e ctrl);
    return is_byte(ctrl) || is_half(ctrl);
  endfunction

  // Halves must be 2-byte aligned, words 4-byte aligned; bytes never fault
  function automatic logic is_misaligned(input dmctrl_e ctrl, input logic [1:0] lane);
    if (is_byte(ctrl)) return 1'b0;
    if (is_half(ctrl)) return lane[0];
    return lane != 2'b00;
  endfunction

  // Pick the addressed lane out of a RAM word and extend it to 32 bits
  function automatic logic [31:0] load_extend(input logic [31:0] word, input dmctrl_e ctrl,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (ctrl)
      DM_B:    return {{24{b[7]}}, b};
      DM_BU:   return {24'h0, b};
      DM_H:    return {{16{h[15]}}, h};
      DM_HU:   return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Insert the low byte/half of the store data into the addressed lane of the old word
  function automatic logic [31:0] store_merge(input logic [31:0] word, input dmctrl_e ctrl,
                                              input logic [1:0] lane, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (is_byte(ctrl)) begin
      r[{lane, 3'b000} +: 8] = wd[7:0];
    end else if (is_half(ctrl)) begin
      if (lane[1]) r[31:16] = wd;
      else         r[15:0]  = wd;
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// rtl/dm_ram.sv - single-port synchronous word RAM with one-cycle read latency
module dm_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write when enabled; always register the old contents of the addressed word
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store controller over word RAM with RMW sub-word stores (option: MISALIGN_TRAP_EN)
module data_mem_ctrl
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              DMWr,
  input  logic [2:0]        DMCtrl,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataWr,
  output logic              rsp_valid,
  output logic [31:0]       DataRd,
  output logic              fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dm_state_e   state_q, state_d;
  dmctrl_e     ctrl_q, ctrl_d;
  logic [1:0]  lane_q, lane_d;
  logic [AW-1:0] word_q, word_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] data_rd_q, data_rd_d;
  logic        fault_q, fault_d;

  logic          accept;
  logic          trap;
  dmctrl_e       req_ctrl;
  logic [AW-1:0] req_word;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_q;
  logic          unused_addr_bits;

  // Word index wraps modulo the RAM depth; upper address bits are deliberately dropped
  assign req_word         = Address[AW+1:2];
  assign unused_addr_bits = ^Address[ADDR_W-1:AW+2];
  assign req_ctrl         = dmctrl_e'(DMCtrl);
  assign accept           = req_valid && (state_q == IDLE) && !rst;

`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_ctrl, Address[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign DataRd    = data_rd_q;
  assign fault     = fault_q;

  // Next state, request capture and RAM port control
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    lane_d    = lane_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    data_rd_d = data_rd_q;
    fault_d   = fault_q;
    ram_we    = 1'b0;
    ram_addr  = word_q;
    ram_wdata = store_merge(ram_q, ctrl_q, lane_q, wdata_q);
    case (state_q)
      IDLE: begin
        // The read for loads and sub-word stores is launched from the live request at T
        ram_addr = req_word;
        if (accept) begin
          ctrl_d  = req_ctrl;
          lane_d  = Address[1:0];
          word_d  = req_word;
          wdata_d = DataWr[15:0];
          fault_d = trap;
          if (trap) begin
            data_rd_d = 32'h0;
            state_d   = RESP;
          end else if (DMWr && !is_subword(req_ctrl)) begin
            ram_we    = 1'b1;
            ram_wdata = DataWr;
            state_d   = RESP;
          end else if (DMWr) begin
            // Sub-word store: read data is available next cycle, so merge there directly
            state_d = RMW;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        data_rd_d = load_extend(ram_q, ctrl_q, lane_q);
        state_d   = RESP;
      end
      RMW: begin
        ram_we  = !rst;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctrl_q    <= DM_W;
      lane_q    <= 2'b00;
      word_q    <= '0;
      wdata_q   <= 16'h0;
      data_rd_q <= 32'h0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      lane_q    <= lane_d;
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      data_rd_q <= data_rd_d;
      fault_q   <= fault_d;
    end
  end

  dm_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

endmodule
